// File: rtl/prio_enc_rr.sv
// Registered N-input priority encoder/arbiter with a valid/ready grant output.
// Mode 0 is fixed priority (lowest index wins); mode 1 is round-robin starting after the last accepted grant.
module prio_enc_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] ptr
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic [W-1:0] next_ptr;
  logic [W-1:0] search_start;
  logic [W-1:0] probe;
  logic [W-1:0] win_idx;
  logic         win_found;

  assign accept   = (state == GRANT) && out_ready;
  assign next_ptr = (out_idx == W'(N - 1)) ? '0 : out_idx + W'(1);

  // A back-to-back search starts just after the index being accepted, which is the value ptr is about to take.
  assign search_start = !mode ? '0 : ((state == GRANT) ? next_ptr : ptr);

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int i = 0; i < N; i++) begin
      probe = W'((int'(search_start) + i) % N);
      if (!win_found && req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = GRANT;
      GRANT:   if (out_ready) state_next = win_found ? GRANT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == GRANT);
  end

  // Grant registers load only when a new winner is taken; a stalled grant holds whatever req does.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= '0;
    end else begin
      if (accept) begin
        ptr <= next_ptr;
      end
      if (((state == IDLE) || accept) && win_found) begin
        out_idx    <= win_idx;
        out_onehot <= N'(1) << win_idx;
      end else if (accept) begin
        out_onehot <= '0;
      end
    end
  end

endmodule
